// File: rtl/lift_pkg.sv
// lift_pkg: shared floor constants, scheduler state encoding and SW decode helper.
package lift_pkg;
  localparam int N_FLOORS = 9;
  localparam int FLOOR_W = 4;
  typedef enum logic [1:0] {IDLE, SERVE_UP, SERVE_DOWN} state_e;
  typedef struct packed {
    logic valid;
    logic [FLOOR_W-1:0] idx;
  } sel_t;
  function automatic sel_t onehot_to_idx(input logic [N_FLOORS-1:0] v);
    sel_t s;
    s = '0;
    for (int i = 0; i < N_FLOORS; i++) if (v[i]) s.idx = FLOOR_W'(i);
    s.valid = $onehot(v);
    return s;
  endfunction
endpackage

// File: rtl/lift_request_scheduler_if.sv
// lift_request_scheduler_if: request inputs and target outputs between the panel/motion FSM and the scheduler.
interface lift_request_scheduler_if;
  import lift_pkg::*;
  logic [N_FLOORS-1:0] SW;
  logic KEY0;
  logic [FLOOR_W-1:0] current_floor;
  logic arrived;
  logic [FLOOR_W-1:0] target_floor;
  logic target_valid;
  logic [N_FLOORS-1:0] pending;
  logic dir_up;
  logic req_reject;
  modport master (output SW, KEY0, current_floor, arrived,
                  input target_floor, target_valid, pending, dir_up, req_reject);
  modport slave (input SW, KEY0, current_floor, arrived,
                 output target_floor, target_valid, pending, dir_up, req_reject);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchroniser, optional stable-level counter (LIFT_DEBOUNCE_EN), press pulse on 1->0.
module key_debouncer #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);
  logic [1:0] sync_q;
  logic deb_lvl, prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], key_i};
      prev_q <= deb_lvl;
    end
`ifdef LIFT_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic lvl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else if (sync_q[1] == lvl_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      cnt_q <= '0;
      lvl_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  assign deb_lvl = lvl_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES > 0);
  assign deb_lvl = sync_q[1];
`endif
  assign press_o = prev_q & ~deb_lvl;
endmodule

// File: rtl/lift_request_scheduler.sv
// lift_request_scheduler: latches debounced floor calls and picks the next target with a SCAN policy.
// Debounce counter is built only when LIFT_DEBOUNCE_EN is defined.
module lift_request_scheduler
  import lift_pkg::*;
#(
  parameter int DEB_CYCLES = 1000000
) (
  input logic CLOCK_50,
  input logic RESET_N,
  lift_request_scheduler_if.slave bus
);
  logic press, cf_ok, at, up_v, dn_v, go_up, rej_d, rej_q;
  sel_t sel;
  state_e state_q;
  logic [N_FLOORS-1:0] cf_oh, clr_m, set_m, eff, pending_d, pending_q;
  logic [FLOOR_W-1:0] up_idx, dn_idx, tgt_q;
  logic valid_q, dir_q;
  key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk(CLOCK_50), .rst_n(RESET_N), .key_i(bus.KEY0), .press_o(press)
  );
  // cf_oh is zero for an out-of-range floor, so arrival and the at-floor test vanish there
  assign cf_oh = N_FLOORS'(1) << bus.current_floor;
  assign cf_ok = bus.current_floor < FLOOR_W'(N_FLOORS);
  assign sel = onehot_to_idx(bus.SW);
  assign clr_m = bus.arrived ? cf_oh : '0;
  assign set_m = (press && sel.valid && !(state_q == IDLE && sel.idx == bus.current_floor))
                 ? N_FLOORS'(1) << sel.idx : '0;
  assign pending_d = (pending_q | set_m) & ~clr_m;
  assign rej_d = press & ~sel.valid;
  // The scheduler sees the bitmap with the arriving floor already served
  assign eff = pending_q & ~clr_m;
  assign at = |(eff & cf_oh);
  always_comb begin
    up_v = 1'b0;
    dn_v = 1'b0;
    up_idx = '0;
    dn_idx = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--)
      if (eff[i] && FLOOR_W'(i) > bus.current_floor) begin
        up_v = 1'b1;
        up_idx = FLOOR_W'(i);
      end
    for (int i = 0; i < N_FLOORS; i++)
      if (eff[i] && FLOOR_W'(i) < bus.current_floor) begin
        dn_v = 1'b1;
        dn_idx = FLOOR_W'(i);
      end
  end
  assign go_up = !at && up_v && (!dn_v || (up_idx - bus.current_floor) < (bus.current_floor - dn_idx));
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      pending_q <= '0;
      rej_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rej_q <= rej_d;
    end
  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= IDLE;
      tgt_q <= '0;
      valid_q <= 1'b0;
      dir_q <= 1'b1;
    end else if (cf_ok) begin
      valid_q <= 1'b1;
      case (state_q)
        SERVE_UP:
          if (up_v) tgt_q <= up_idx;
          else if (dn_v) begin
            state_q <= SERVE_DOWN;
            tgt_q <= dn_idx;
            dir_q <= 1'b0;
          end else if (at) tgt_q <= bus.current_floor;
          else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        SERVE_DOWN:
          if (dn_v) tgt_q <= dn_idx;
          else if (up_v) begin
            state_q <= SERVE_UP;
            tgt_q <= up_idx;
            dir_q <= 1'b1;
          end else if (at) tgt_q <= bus.current_floor;
          else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dir_q <= 1'b1;
          end
        default:
          if (go_up) begin
            state_q <= SERVE_UP;
            tgt_q <= up_idx;
            dir_q <= 1'b1;
          end else if (|eff) begin
            state_q <= SERVE_DOWN;
            tgt_q <= at ? bus.current_floor : dn_idx;
            dir_q <= 1'b0;
          end else begin
            valid_q <= 1'b0;
            dir_q <= 1'b1;
          end
      endcase
    end
  assign bus.pending = pending_q;
  assign bus.req_reject = rej_q;
  assign bus.target_floor = tgt_q;
  assign bus.target_valid = valid_q;
  assign bus.dir_up = dir_q;
endmodule

// File: tb/tb_lift_request_scheduler.sv
// tb_lift_request_scheduler: table-driven press vectors plus hand sequences for arrival, range and reset corners.
module tb_lift_request_scheduler;
  import lift_pkg::*;
  localparam int DEB = 8;
`ifdef LIFT_DEBOUNCE_EN
  localparam int PL = DEB + 2;
`else
  localparam int PL = 2;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  lift_request_scheduler_if bus();
  lift_request_scheduler #(.DEB_CYCLES(DEB)) dut (.CLOCK_50(clk), .RESET_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [8:0] sw;
    logic [3:0] cf;
    logic arr;
    logic [8:0] pend;
    logic rej;
    logic [3:0] tgt;
    logic vld;
    logic dir;
  } vec_t;
  vec_t vt[10];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string nm, input logic [8:0] p, input logic [3:0] t, input logic v, input logic d);
    check({nm, ".pending"}, 32'(bus.pending), 32'(p));
    check({nm, ".target_floor"}, 32'(bus.target_floor), 32'(t));
    check({nm, ".target_valid"}, 32'(bus.target_valid), 32'(v));
    check({nm, ".dir_up"}, 32'(bus.dir_up), 32'(d));
  endtask
  task automatic apply(input int i);
    string nm;
    nm = $sformatf("vec%0d", i);
    bus.SW = vt[i].sw;
    bus.current_floor = vt[i].cf;
    bus.KEY0 = 1'b0;
    repeat (PL) tick();
    bus.arrived = vt[i].arr;
    tick();
    bus.arrived = 1'b0;
    check({nm, ".pending+1"}, 32'(bus.pending), 32'(vt[i].pend));
    check({nm, ".req_reject+1"}, 32'(bus.req_reject), 32'(vt[i].rej));
    tick();
    outs({nm, "+2"}, vt[i].pend, vt[i].tgt, vt[i].vld, vt[i].dir);
    check({nm, ".req_reject+2"}, 32'(bus.req_reject), 32'd0);
    bus.KEY0 = 1'b1;
    repeat (PL + 2) tick();
  endtask
  task automatic arrive(input logic [3:0] cf);
    bus.current_floor = cf;
    bus.arrived = 1'b1;
    tick();
    bus.arrived = 1'b0;
  endtask
  initial begin
    vt[0] = '{9'h020, 4'd0, 1'b0, 9'h020, 1'b0, 4'd5, 1'b1, 1'b1};
    vt[1] = '{9'h003, 4'd0, 1'b0, 9'h020, 1'b1, 4'd5, 1'b1, 1'b1};
    vt[2] = '{9'h000, 4'd0, 1'b0, 9'h020, 1'b1, 4'd5, 1'b1, 1'b1};
    vt[3] = '{9'h040, 4'd5, 1'b1, 9'h040, 1'b0, 4'd6, 1'b1, 1'b1};
    vt[4] = '{9'h100, 4'd4, 1'b0, 9'h140, 1'b0, 4'd6, 1'b1, 1'b1};
    vt[5] = '{9'h004, 4'd4, 1'b0, 9'h144, 1'b0, 4'd6, 1'b1, 1'b1};
    vt[6] = '{9'h004, 4'd2, 1'b0, 9'h000, 1'b0, 4'd2, 1'b0, 1'b1};
    vt[7] = '{9'h001, 4'd3, 1'b0, 9'h001, 1'b0, 4'd0, 1'b1, 1'b0};
    vt[8] = '{9'h008, 4'd3, 1'b1, 9'h001, 1'b0, 4'd0, 1'b1, 1'b0};
    vt[9] = '{9'h080, 4'd3, 1'b1, 9'h081, 1'b0, 4'd0, 1'b1, 1'b0};
    bus.SW = '0;
    bus.KEY0 = 1'b1;
    bus.current_floor = '0;
    bus.arrived = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    outs("reset", 9'h000, 4'd0, 1'b0, 1'b1);
    check("reset.req_reject", 32'(bus.req_reject), 32'd0);
    for (int i = 0; i < 6; i++) apply(i);
    arrive(4'd6);
    outs("arr6", 9'h104, 4'd8, 1'b1, 1'b1);
    arrive(4'd8);
    outs("arr8", 9'h004, 4'd2, 1'b1, 1'b0);
    arrive(4'd2);
    outs("arr2", 9'h000, 4'd2, 1'b0, 1'b1);
    tick();
    check("idle.target_valid", 32'(bus.target_valid), 32'd0);
    for (int i = 6; i < 10; i++) apply(i);
    arrive(4'd12);
    tick();
    outs("cf_range", 9'h081, 4'd0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 outs("mid_reset", 9'h000, 4'd0, 1'b0, 1'b1);
    bus.current_floor = '0;
    tick();
    rst_n = 1'b1;
    tick();
`ifdef LIFT_DEBOUNCE_EN
    begin
      int rej;
      rej = 0;
      bus.SW = '0;
      repeat (4) begin
        bus.KEY0 = 1'b0;
        repeat (3) begin tick(); rej += int'(bus.req_reject); end
        bus.KEY0 = 1'b1;
        repeat (2) begin tick(); rej += int'(bus.req_reject); end
      end
      repeat (14) begin tick(); rej += int'(bus.req_reject); end
      check("bounce.rejects", 32'(rej), 32'd0);
      bus.KEY0 = 1'b0;
      repeat (16) begin tick(); rej += int'(bus.req_reject); end
      bus.KEY0 = 1'b1;
      repeat (14) begin tick(); rej += int'(bus.req_reject); end
      check("long_low.rejects", 32'(rej), 32'd1);
      bus.SW = 9'h010;
      bus.KEY0 = 1'b0;
      repeat (6) tick();
      rst_n = 1'b0;
      #1 check("deb_reset.pending", 32'(bus.pending), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      check("deb_restart.early", 32'(bus.pending), 32'd0);
      repeat (6) tick();
      check("deb_restart.late", 32'(bus.pending), 32'h010);
      bus.KEY0 = 1'b1;
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
